// File: rtl/rate_sequence_ctrl.sv
// Slow-tick timebase sequencer: ticks at a selectable rate, STEP_TICKS per step.
// Define SEQ_WRAP_EN to let auto-step wrap from rate 11 back to 00 instead of finishing.
module rate_sequence_ctrl #(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned CNT_W      = 28,
   parameter int unsigned STEP_TICKS = 16
) (
   input  logic       clock50M,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       pause,
   input  logic [1:0] rate_sel,
   input  logic       auto_step,
   output logic       tick,
   output logic [1:0] rate_cur,
   output logic [3:0] tick_count,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      HOLD
   } state_t;

   localparam logic [CNT_W-1:0] R1   = CNT_W'(CLK_HZ - 1);
   localparam logic [CNT_W-1:0] R2   = CNT_W'(2 * CLK_HZ - 1);
   localparam logic [CNT_W-1:0] R3   = CNT_W'(4 * CLK_HZ - 1);
   localparam logic [3:0]       LAST = 4'(STEP_TICKS - 1);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic [3:0]       tc_next;
   logic [1:0]       rate_next;
   logic             tick_next;
   logic             done_next;
   logic             advance;

   function automatic logic [CNT_W-1:0] reload(input logic [1:0] code);
      logic [CNT_W-1:0] r;
      unique case (code)
         2'b00:   r = '0;
         2'b01:   r = R1;
         2'b10:   r = R2;
         default: r = R3;
      endcase
      return r;
   endfunction

`ifdef SEQ_WRAP_EN
   // Rate code simply rolls over, so auto-step never terminates.
   assign advance = auto_step;
`else
   assign advance = auto_step && (rate_cur != 2'b11);
`endif

   always_comb begin
      state_next = state;
      count_next = count;
      tc_next    = tick_count;
      rate_next  = rate_cur;
      tick_next  = 1'b0;
      done_next  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start && !stop) begin
               state_next = LOAD;
               rate_next  = rate_sel;
            end
         end
         LOAD: begin
            count_next = reload(rate_cur);
            tc_next    = '0;
            state_next = RUN;
         end
         RUN: begin
            if (stop) begin
               state_next = IDLE;
            end else if (pause) begin
               state_next = HOLD;
            end else if (count == '0) begin
               tick_next  = 1'b1;
               count_next = reload(rate_cur);
               if (tick_count == LAST) begin
                  tc_next = '0;
                  if (advance) begin
                     rate_next  = rate_cur + 2'd1;
                     state_next = LOAD;
                  end else begin
                     done_next  = 1'b1;
                     state_next = IDLE;
                  end
               end else begin
                  tc_next = tick_count + 4'd1;
               end
            end else begin
               count_next = count - CNT_W'(1);
            end
         end
         HOLD: begin
            if (stop) begin
               state_next = IDLE;
            end else if (!pause) begin
               state_next = RUN;
            end
         end
      endcase
   end

   // busy follows the next state so it is already low alongside done.
   always_ff @(posedge clock50M) begin
      if (reset) begin
         state      <= IDLE;
         count      <= '0;
         tick_count <= '0;
         rate_cur   <= 2'b00;
         tick       <= 1'b0;
         done       <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_next;
         count      <= count_next;
         tick_count <= tc_next;
         rate_cur   <= rate_next;
         tick       <= tick_next;
         done       <= done_next;
         busy       <= (state_next != IDLE);
      end
   end

endmodule

// File: tb/tb_rate_sequence_ctrl.sv
// Bench for rate_sequence_ctrl: directed timing pins plus randomized traffic
// compared each cycle against a cycle-budget model of the sequencer.
module tb_rate_sequence_ctrl;

   localparam int CLK_HZ = 4;
   localparam int STEP   = 4;
`ifdef SEQ_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   localparam int P_IDLE = 0;
   localparam int P_LOAD = 1;
   localparam int P_RUN  = 2;
   localparam int P_HOLD = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       pause = 1'b0;
   logic       auto_step = 1'b0;
   logic [1:0] rate_sel = 2'b00;
   logic       tick;
   logic       busy;
   logic       done;
   logic [1:0] rate_cur;
   logic [3:0] tick_count;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   rate_sequence_ctrl #(
      .CLK_HZ    (CLK_HZ),
      .CNT_W     (28),
      .STEP_TICKS(STEP)
   ) dut (
      .clock50M  (clk),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .pause     (pause),
      .rate_sel  (rate_sel),
      .auto_step (auto_step),
      .tick      (tick),
      .rate_cur  (rate_cur),
      .tick_count(tick_count),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: cycles remaining until the next tick, and ticks issued this step.
   int ph = P_IDLE;
   int due = 0;
   int e_rate = 0;
   int e_tc = 0;
   bit e_tick = 1'b0;
   bit e_done = 1'b0;
   bit e_busy = 1'b0;

   function automatic int period(input int r);
      if (r == 0) return 1;
      return CLK_HZ * (1 << (r - 1));
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         ph = P_IDLE;
         e_tick = 0;
         e_done = 0;
         e_busy = 0;
         e_rate = 0;
         e_tc = 0;
         due = 0;
      end else begin
         e_tick = 0;
         e_done = 0;
         if (ph == P_IDLE) begin
            if (start && !stop) begin
               ph = P_LOAD;
               e_rate = int'(rate_sel);
            end
         end else if (ph == P_LOAD) begin
            due = period(e_rate);
            e_tc = 0;
            ph = P_RUN;
         end else if (stop) begin
            ph = P_IDLE;
         end else if (ph == P_HOLD) begin
            if (!pause) ph = P_RUN;
         end else if (pause) begin
            ph = P_HOLD;
         end else begin
            due = due - 1;
            if (due == 0) begin
               e_tick = 1;
               due = period(e_rate);
               if (e_tc + 1 == STEP) begin
                  e_tc = 0;
                  if (auto_step && (WRAP || e_rate != 3)) begin
                     e_rate = (e_rate + 1) % 4;
                     ph = P_LOAD;
                  end else begin
                     e_done = 1;
                     ph = P_IDLE;
                  end
               end else begin
                  e_tc = e_tc + 1;
               end
            end
         end
         e_busy = (ph != P_IDLE);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("tick", 32'(tick), 32'(e_tick));
         check("done", 32'(done), 32'(e_done));
         check("busy", 32'(busy), 32'(e_busy));
         check("rate_cur", 32'(rate_cur), 32'(e_rate));
         check("tick_count", 32'(tick_count), 32'(e_tc));
      end
   end

   int   ticks_q[$];
   int   tcs_q[$];
   int   done_cyc;
   logic busy_h[0:199];
   int   rate_h[0:199];

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0;
      stop = 1'b0;
      pause = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Start at edge 0; cycle n is the interval after edge n-1.
   task automatic run_seq(input logic [1:0] rs, input logic au, input int ncyc);
      ticks_q.delete();
      tcs_q.delete();
      done_cyc = -1;
      @(negedge clk);
      rate_sel = rs;
      auto_step = au;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 1; n <= ncyc; n++) begin
         if (tick) begin
            ticks_q.push_back(n);
            tcs_q.push_back(int'(tick_count));
         end
         if (done && done_cyc < 0) done_cyc = n;
         if (n < 200) begin
            busy_h[n] = busy;
            rate_h[n] = int'(rate_cur);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b1;
      @(posedge clk);
      cmp_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_tick", 32'(tick), 0);
      check("rst_done", 32'(done), 0);
      check("rst_tick_count", 32'(tick_count), 0);
      check("rst_rate_cur", 32'(rate_cur), 0);
      reset = 1'b0;
      start = 1'b0;

      // rate 00, single step
      do_reset();
      run_seq(2'b00, 1'b0, 12);
      check("r0_ntick", ticks_q.size(), 4);
      check("r0_t0", ticks_q[0], 3);
      check("r0_t3", ticks_q[3], 6);
      check("r0_done", done_cyc, 6);
      check("r0_busy1", 32'(busy_h[1]), 1);
      check("r0_busy5", 32'(busy_h[5]), 1);
      check("r0_busy6", 32'(busy_h[6]), 0);

      // rate 01, single step
      do_reset();
      run_seq(2'b01, 1'b0, 24);
      check("r1_ntick", ticks_q.size(), 4);
      check("r1_t0", ticks_q[0], 6);
      check("r1_t1", ticks_q[1], 10);
      check("r1_t2", ticks_q[2], 14);
      check("r1_t3", ticks_q[3], 18);
      check("r1_done", done_cyc, 18);
      check("r1_tc0", tcs_q[0], 1);
      check("r1_tc1", tcs_q[1], 2);
      check("r1_tc2", tcs_q[2], 3);
      check("r1_tc3", tcs_q[3], 0);

      // rate 10 auto-stepping into rate 11 (one LOAD cycle between steps)
      do_reset();
      run_seq(2'b10, 1'b1, 105);
      check("a_t0", ticks_q[0], 10);
      check("a_t3", ticks_q[3], 34);
      check("a_t4", ticks_q[4], 51);
      check("a_t7", ticks_q[7], 99);
      check("a_rate40", rate_h[40], 3);
`ifdef SEQ_WRAP_EN
      check("a_nodone", done_cyc, -1);
      check("a_rate100", rate_h[100], 0);
`else
      check("a_done", done_cyc, 99);
      check("a_busy100", 32'(busy_h[100]), 0);
`endif

      // pause then stop from HOLD
      do_reset();
      @(negedge clk);
      rate_sel = 2'b01;
      auto_step = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("p_first_tick", 32'(tick), 1);
      pause = 1'b1;
      repeat (10) @(negedge clk);
      pause = 1'b0;
      repeat (3) @(negedge clk);
      pause = 1'b1;
      @(negedge clk);
      check("p_held_busy", 32'(busy), 1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      pause = 1'b0;
      check("p_stop_busy", 32'(busy), 0);
      check("p_stop_tick", 32'(tick), 0);
      check("p_stop_done", 32'(done), 0);

      // start while busy, and start+stop in IDLE
      do_reset();
      @(negedge clk);
      rate_sel = 2'b01;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rate_sel = 2'b11;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("i_rate_kept", 32'(rate_cur), 1);
      do_reset();
      start = 1'b1;
      stop = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop = 1'b0;
      check("i_ss_busy0", 32'(busy), 0);
      @(negedge clk);
      check("i_ss_busy1", 32'(busy), 0);
      check("i_ss_rate", 32'(rate_cur), 0);

      // randomized traffic against the model
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 299) == 0);
         start = ($urandom_range(0, 7) == 0);
         stop = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 11) == 0) pause = ~pause;
         rate_sel = 2'($urandom);
         if ($urandom_range(0, 19) == 0) auto_step = ~auto_step;
      end
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      stop = 1'b0;
      pause = 1'b0;
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
